key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and synchronises the seven raw organ keys, producing clean, registered key levels for the seven-segment display driver and the tone generator. It sits directly upstream of the seven-segment display stage and drives its `key[6:0]` input. The `key` output is one-hot: only the lowest-index pressed key is asserted. The block also emits one-cycle press pulses for note-on logic.

## Interface

Parameters:
- `N_KEYS`, 7, number of keys.
- `TICK_DIV`, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal values are 2 or more.
- `STABLE_TICKS`, 10, consecutive mismatching ticks required to accept a new level; legal values are 1 or more.

Ports:
- `clk`  in  1  system clock. One clock; all logic is on its rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `key_raw`  in  N_KEYS  raw buttons, active-high (1 = pressed), asynchronous to clk, bouncing.
- `key_level`  out  N_KEYS  debounced level of every key.
- `key`  out  N_KEYS  one-hot lowest-index pressed key, or all-zero; feeds the display stage.
- `press`  out  N_KEYS  one-cycle pulse per key on each debounced 0→1 transition.
- `any_key`  out  1  OR of `key_level`.

## Operation

- Synchroniser: a 2-FF chain per bit gives `key_sync`.
- Tick generator: free-running counter `tick_cnt` over 0..TICK_DIV-1. `tick` is high for one cycle when `tick_cnt == TICK_DIV-1`, then the counter wraps to 0.
- Per-key cell: holds state `level` (1 bit) and `cnt` (width clog2(STABLE_TICKS+1)). On each cycle with `tick`:
  - if `key_sync == level`, then `cnt <= 0`;
  - else if `cnt == STABLE_TICKS-1`, then `level <= key_sync` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
  - No state changes on non-tick cycles.
- Cell state machine:
  - STABLE (`cnt == 0`) → COUNTING on a mismatch at a tick.
  - COUNTING → STABLE on a match at a tick (bounce rejected).
  - COUNTING → STABLE with `level` flipped when the count completes.
- Outputs, all registered from `level`:
  - `key_level <= level`.
  - `press[i] <= level[i] & ~key_level[i]`.
  - `key <=` priority one-hot of `level`; lowest index wins.
  - `any_key <= |level`.
- Simultaneous presses: several keys may flip on the same tick. `key_level` and `press` show all of them. `key` shows only the lowest index.
- Release of the key shown on `key` while a higher key is held: on the next update, `key` moves to the next-lowest held key. No `press` pulse is generated for it.

## Timing

- Reset (async assert, sync release is the system's concern): `key_level`, `key`, `press`, `any_key` = 0; all `level`, `cnt`, `tick_cnt` and synchroniser flops = 0.
- Assertion of `rst_n` mid-count discards partial counts. After release, a held key is re-accepted after a full `STABLE_TICKS` ticks.
- Latency from a clean raw edge to `key_level`: 2 sync cycles, plus the wait to the next tick, plus (STABLE_TICKS-1) further ticks, plus 2 register cycles.
  - Maximum: 4 + STABLE_TICKS·TICK_DIV cycles.
- `press` is high for exactly one cycle. It is coincident with the first cycle in which `key_level[i]`, `key` and `any_key` reflect the new state.
- Glitches shorter than STABLE_TICKS ticks never reach any output.

## Structure

- Shared package `organ_pkg`:
  - `N_KEYS` constant (7);
  - `key_vec_t` (logic [N_KEYS-1:0]);
  - default `TICK_DIV` and `STABLE_TICKS` constants.
  - The display stage also imports this package.
- Sub-module `key_debounce_cell`: one bit, containing the synchroniser and the `level`/`cnt` logic with a `tick` input. It is instantiated N_KEYS times with a generate loop.
- The tick generator and the priority/pulse output registers stay in `key_debounce`.

## Test plan

All scenarios use TICK_DIV=4 and STABLE_TICKS=3.

- Reset: hold `rst_n`=0 with `key_raw`=7'h7F → all outputs 0. Release → `key_level`=7'h7F after ≤16 cycles; `key`=7'h01; `press`=7'h7F for one cycle.
- Clean press: `key_raw[2]` 0→1 held → `key_level`=7'h04, `key`=7'h04, `press`=7'h04 for exactly one cycle, within 4+12 cycles. Release → `key_level`=0 with no `press`.
- Bounce rejection: toggle `key_raw[5]` every 5 cycles for 60 cycles, then hold 0 → `key_level[5]` stays 0 throughout and `press` never fires.
- Priority: hold keys 4 and 1 → `key`=7'h02, `key_level`=7'h12. Release key 1 → `key`=7'h10, no `press`.
- Simultaneous: keys 0 and 6 rise in the same cycle → both `press` bits are high in the same cycle; `key`=7'h01; `any_key`=1.
- Mid-count reset: press key 3, and pulse `rst_n` low after 2 ticks → outputs return to 0. After release, `key_level[3]` rises only 3 full ticks later.

Source files
------------

// File: rtl/organ_pkg.sv
// Shared organ constants and key vector type, used by the debouncer and the display stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package organ_pkg;
    localparam int N_KEYS           = 7;
    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 10;

    typedef logic [N_KEYS-1:0] key_vec_t;
endpackage

// File: rtl/key_debounce_cell.sv
// One-key debouncer: 2-FF synchroniser plus tick-sampled stability counter.
// Latency: 2 sync cycles, then STABLE_TICKS mismatching ticks before level flips.
// Backpressure: none; free-running.
module key_debounce_cell #(
    parameter int STABLE_TICKS = organ_pkg::STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic          sync_1;
    logic          key_sync;
    logic [CW-1:0] cnt;

    // cnt == 0 is the STABLE state; any non-zero count means a candidate level is being timed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            key_sync <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_1   <= raw;
            key_sync <= sync_1;
            if (tick) begin
                if (key_sync == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_TICKS - 1)) begin
                    level <= key_sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/key_debounce.sv
// Debounces the organ keys and registers level, lowest-key one-hot, press pulses and any-key.
// Latency: raw edge to outputs 2 sync + up to STABLE_TICKS*TICK_DIV + 2 register cycles.
// Backpressure: none; outputs are plain registered levels and one-cycle pulses.
module key_debounce #(
    parameter int N_KEYS       = organ_pkg::N_KEYS,
    parameter int TICK_DIV     = organ_pkg::TICK_DIV_DEF,
    parameter int STABLE_TICKS = organ_pkg::STABLE_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] press,
    output logic              any_key
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] lowest;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_cell
        key_debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (key_raw[g]),
            .level(level[g])
        );
    end

    // Two's-complement trick isolates the lowest set bit.
    assign lowest = level & (~level + N_KEYS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= '0;
            key       <= '0;
            press     <= '0;
            any_key   <= 1'b0;
        end else begin
            key_level <= level;
            key       <= lowest;
            press     <= level & ~key_level;
            any_key   <= |level;
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_key_debounce;
    import organ_pkg::*;

    logic     clk;
    logic     rst_n;
    key_vec_t key_raw;
    key_vec_t key_level;
    key_vec_t key;
    key_vec_t press;
    logic     any_key;

    key_debounce #(
        .N_KEYS      (N_KEYS),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (key_raw),
        .key_level(key_level),
        .key      (key),
        .press    (press),
        .any_key  (any_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        key_vec_t raw;
        key_vec_t lvl;
        key_vec_t key;
        key_vec_t press;
        logic     any;
    } vec_t;

    vec_t     tbl[7];
    int       n_vec = 0;
    int       n_bad = 0;
    key_vec_t prev_lvl = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sample at the falling edge; press must equal the rising edges of key_level in the same cycle.
    task automatic samp();
        @(negedge clk);
        cmp("press_edge", 32'(press), 32'(key_level & ~prev_lvl));
        prev_lvl = key_level;
    endtask

    task automatic measure(input key_vec_t lvl, output int first, output key_vec_t p_at,
                           output key_vec_t p_or);
        first = 0;
        p_at  = '0;
        p_or  = '0;
        for (int c = 1; c <= 20; c++) begin
            samp();
            p_or |= press;
            if (first == 0 && key_level == lvl) begin
                first = c;
                p_at  = press;
            end
        end
    endtask

    initial begin
        int       first;
        key_vec_t p_at;
        key_vec_t p_or;
        int       viol;

        tbl[0] = '{raw: 7'h00, lvl: 7'h00, key: 7'h00, press: 7'h00, any: 1'b0};
        tbl[1] = '{raw: 7'h04, lvl: 7'h04, key: 7'h04, press: 7'h04, any: 1'b1};
        tbl[2] = '{raw: 7'h00, lvl: 7'h00, key: 7'h00, press: 7'h00, any: 1'b0};
        tbl[3] = '{raw: 7'h12, lvl: 7'h12, key: 7'h02, press: 7'h12, any: 1'b1};
        tbl[4] = '{raw: 7'h10, lvl: 7'h10, key: 7'h10, press: 7'h00, any: 1'b1};
        tbl[5] = '{raw: 7'h00, lvl: 7'h00, key: 7'h00, press: 7'h00, any: 1'b0};
        tbl[6] = '{raw: 7'h41, lvl: 7'h41, key: 7'h01, press: 7'h41, any: 1'b1};

        // Reset with every key held, then release.
        rst_n   = 1'b0;
        key_raw = 7'h7F;
        repeat (3) samp();
        cmp("rst_level", 32'(key_level), 32'h0);
        cmp("rst_key", 32'(key), 32'h0);
        cmp("rst_press", 32'(press), 32'h0);
        cmp("rst_any", 32'(any_key), 32'h0);
        rst_n = 1'b1;
        measure(7'h7F, first, p_at, p_or);
        cmp("rst_rel_latency", 32'(first), 32'd13);
        cmp("rst_rel_key", 32'(key), 32'h01);
        cmp("rst_rel_press_at", 32'(p_at), 32'h7F);
        cmp("rst_rel_press_all", 32'(p_or), 32'h7F);
        cmp("rst_rel_any", 32'(any_key), 32'h1);

        for (int i = 0; i < 7; i++) begin
            key_raw = tbl[i].raw;
            measure(tbl[i].lvl, first, p_at, p_or);
            n_vec++;
            if (first < 12 || first > 16) begin
                n_bad++;
                $display("FAIL vec%0d_latency: got %0d cycles, required 12..16", i, first);
            end
            cmp($sformatf("vec%0d_level", i), 32'(key_level), 32'(tbl[i].lvl));
            cmp($sformatf("vec%0d_key", i), 32'(key), 32'(tbl[i].key));
            cmp($sformatf("vec%0d_any", i), 32'(any_key), 32'(tbl[i].any));
            cmp($sformatf("vec%0d_press_at", i), 32'(p_at), 32'(tbl[i].press));
            cmp($sformatf("vec%0d_press_all", i), 32'(p_or), 32'(tbl[i].press));
        end

        key_raw = 7'h00;
        repeat (20) samp();

        // Bounce: key 5 toggles every 5 cycles, never stable for 3 ticks.
        viol = 0;
        for (int c = 0; c < 60; c++) begin
            key_raw = {1'b0, ((c / 5) % 2 == 0), 5'b0};
            samp();
            if (key_level[5] || press[5]) viol++;
        end
        key_raw = 7'h00;
        for (int c = 0; c < 20; c++) begin
            samp();
            if (key_level[5] || press[5]) viol++;
        end
        cmp("bounce_cycles_with_key5", 32'(viol), 32'h0);
        cmp("bounce_level", 32'(key_level), 32'h0);

        // Mid-count reset: two ticks into counting key 3, pulse reset.
        key_raw = 7'h08;
        repeat (10) samp();
        cmp("mid_pre_level", 32'(key_level), 32'h0);
        rst_n = 1'b0;
        samp();
        cmp("mid_rst_level", 32'(key_level), 32'h0);
        cmp("mid_rst_key", 32'(key), 32'h0);
        cmp("mid_rst_any", 32'(any_key), 32'h0);
        rst_n = 1'b1;
        measure(7'h08, first, p_at, p_or);
        cmp("mid_rel_latency", 32'(first), 32'd13);
        cmp("mid_rel_press_at", 32'(p_at), 32'h08);
        cmp("mid_rel_key", 32'(key), 32'h08);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
